dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_pkg.sv | 24 ++
 rtl/rr_arbiter2.sv | 23 ++
 rtl/dmem_arbiter.sv | 149 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the two-port data-memory arbiter.
//   state_t    : arbiter FSM state (IDLE, ACCESS)
//   NPORTS     : number of requester ports (0 = core, 1 = loader/debug)
//   ALIGN_MASK : byte-offset bits that must be zero for a word access
// ---------------------------------------------------------------------------
package dmem_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   localparam int          NPORTS     = 2;
   localparam logic [2:0]  ALIGN_MASK = 3'b111;

   // A word is 8 bytes, so any set bit in the low three address bits
   // means the access straddles a word boundary.
   function automatic logic is_misaligned(input logic [2:0] lsb);
      return |(lsb & ALIGN_MASK);
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin picker, purely combinational.
//   req   [1:0] : active requests
//   last        : index of the port granted most recently
//   grant [1:0] : one-hot grant (all zero when nothing requests)
// A lone requester always wins; on contention the port that was not granted
// last wins.
// ---------------------------------------------------------------------------
module rr_arbiter2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] grant
);

   always_comb begin
      grant = req;
      if (req == 2'b11) begin
         grant = last ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Arbitrates two requesters onto one single-cycle data memory.
//
// Handshake: a requester raises req_i[k] with we/addr/wdata stable and holds
// it until gnt_o[k] is seen high in a cycle; the request is accepted at the
// rising edge ending that cycle, after which req/addr/wdata may change
// freely. done_o[k] pulses for one cycle exactly two cycles after the grant
// cycle; err_o[k] and rdata_o are meaningful only while done_o[k] is high.
//
// Ports
//   clk, rst_n              : clock, asynchronous active-low reset
//   req_i/we_i [k]          : request and write-enable per port
//   addr_i/wdata_i [k]      : byte address and write data per port
//   gnt_o/done_o/err_o [k]  : accept pulse, completion pulse, misalign flag
//   rdata_o                 : read data of the completing access
//   mem_*                   : data-memory address, write data, strobes and
//                             combinational read data
//   dbg_state               : current FSM state, for observation only
// ---------------------------------------------------------------------------
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NPORTS-1:0]              req_i,
   input  logic [NPORTS-1:0]              we_i,
   input  logic [NPORTS-1:0][ADDR_W-1:0]  addr_i,
   input  logic [NPORTS-1:0][DATA_W-1:0]  wdata_i,
   output logic [NPORTS-1:0]              gnt_o,
   output logic [NPORTS-1:0]              done_o,
   output logic [NPORTS-1:0]              err_o,
   output logic [DATA_W-1:0]              rdata_o,
   output logic [ADDR_W-1:0]              mem_addr_o,
   output logic [DATA_W-1:0]              mem_wdata_o,
   output logic                           mem_read_o,
   output logic                           mem_write_o,
   input  logic [DATA_W-1:0]              mem_rdata_i,
   output state_t                         dbg_state
);

   state_t              state_q, state_d;
   logic                last_q;      // port granted most recently
   logic                we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic                port_q;
   logic [NPORTS-1:0]   done_q, err_q;
   logic [DATA_W-1:0]   rdata_q;

   logic [NPORTS-1:0]   pick;
   logic                accept;
   logic                misaligned;

   rr_arbiter2 u_rr (
      .req   (req_i),
      .last  (last_q),
      .grant (pick)
   );

   assign accept     = (state_q == IDLE) && (|req_i);
   assign misaligned = is_misaligned(addr_q[2:0]);
   assign dbg_state  = state_q;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: ACCESS always lasts exactly one cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (|req_i) state_d = ACCESS;
         ACCESS:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output logic: memory side is driven only from latched values
   always_comb begin
      gnt_o       = '0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_read_o  = 1'b0;
      mem_write_o = 1'b0;
      case (state_q)
         IDLE: begin
            // State is already IDLE while reset is held; the gate keeps a
            // pending request from showing a grant during reset.
            if (rst_n) gnt_o = pick;
         end
         ACCESS: begin
            mem_addr_o  = addr_q;
            mem_wdata_o = wdata_q;
            mem_read_o  = !we_q && !misaligned;
            mem_write_o = we_q && !misaligned;
         end
         default: ;
      endcase
   end

   // Request latch and round-robin pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q  <= 1'b1;   // makes port 0 the first winner on contention
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         port_q  <= 1'b0;
      end else if (accept) begin
         last_q  <= pick[1];
         we_q    <= we_i[pick[1]];
         addr_q  <= addr_i[pick[1]];
         wdata_q <= wdata_i[pick[1]];
         port_q  <= pick[1];
      end
   end

   // Completion register: captures the result at the end of ACCESS so
   // done/err/rdata appear together in the following cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_q  <= '0;
         err_q   <= '0;
         rdata_q <= '0;
      end else if (state_q == ACCESS) begin
         done_q  <= {port_q, !port_q};
         err_q   <= misaligned ? {port_q, !port_q} : 2'b00;
         rdata_q <= (!we_q && !misaligned) ? mem_rdata_i : '0;
      end else begin
         done_q  <= '0;
         err_q   <= '0;
         rdata_q <= '0;
      end
   end

   assign done_o  = done_q;
   assign err_o   = err_q;
   assign rdata_o = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed bench for dmem_arbiter with a small word-addressed memory model.
// Drivers push the expected completion (port, err, rdata, cycle) into exp_q
// at grant time; a negedge monitor pops and compares on every done_o pulse.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;
   import dmem_pkg::*;

   localparam int AW = 64;
   localparam int DW = 64;
   localparam logic [63:0] INIT_BASE = 64'hA5A5_0000_0000_0000;

   typedef struct packed {
      logic        port;
      logic        err;
      logic [63:0] rdata;
      logic [31:0] cyc;
   } exp_t;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] cyc = '0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT ----------------
   logic [1:0]          req_i, we_i;
   logic [1:0][AW-1:0]  addr_i;
   logic [1:0][DW-1:0]  wdata_i;
   logic [1:0]          gnt_o, done_o, err_o;
   logic [DW-1:0]       rdata_o;
   logic [AW-1:0]       mem_addr_o;
   logic [DW-1:0]       mem_wdata_o;
   logic                mem_read_o, mem_write_o;
   logic [DW-1:0]       mem_rdata_i;
   state_t              dbg_state;

   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_i       (req_i),
      .we_i        (we_i),
      .addr_i      (addr_i),
      .wdata_i     (wdata_i),
      .gnt_o       (gnt_o),
      .done_o      (done_o),
      .err_o       (err_o),
      .rdata_o     (rdata_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_read_o  (mem_read_o),
      .mem_write_o (mem_write_o),
      .mem_rdata_i (mem_rdata_i),
      .dbg_state   (dbg_state)
   );

   // ---------------- memory model ----------------
   logic [DW-1:0] mem [32];
   always @(posedge clk) begin
      if (mem_write_o) mem[mem_addr_o[7:3]] <= mem_wdata_o;
   end
   assign mem_rdata_i = mem[mem_addr_o[7:3]];

   // ---------------- scoreboard ----------------
   int   checks   = 0;
   int   failures = 0;
   exp_t exp_q[$];
   exp_t mon_e;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_exp(input logic p, input logic err, input logic [63:0] rdata,
                           input logic [31:0] at);
      exp_t e;
      e.port  = p;
      e.err   = err;
      e.rdata = rdata;
      e.cyc   = at;
      exp_q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (done_o != 2'b00) begin
         if (exp_q.size() == 0) begin
            check("done_unexpected", {62'b0, done_o}, 64'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("done_port",  {62'b0, done_o}, mon_e.port ? 64'd2 : 64'd1);
            check("done_cycle", {32'b0, cyc}, {32'b0, mon_e.cyc});
            check("done_err",   {63'b0, err_o[mon_e.port]}, {63'b0, mon_e.err});
            check("done_rdata", rdata_o, mon_e.rdata);
         end
      end
   end

   // ---------------- drivers ----------------
   // One access on a single port, with checks of the IDLE and ACCESS
   // memory-side signals. The port's addr is scrambled right after the
   // grant to show that only the latched value reaches memory.
   task automatic single(input logic p, input logic we, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic exp_err,
                         input logic [63:0] exp_rdata);
      logic got;
      logic aligned;
      @(posedge clk); #1;
      we_i[p] = we; addr_i[p] = addr; wdata_i[p] = wdata; req_i[p] = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (gnt_o[p]) begin got = 1'b1; break; end
      end
      check("grant_seen", {63'b0, got}, 64'd1);
      if (got) begin
         check("grant_onehot", {62'b0, gnt_o}, p ? 64'd2 : 64'd1);
         check("idle_strobes", {62'b0, mem_read_o, mem_write_o}, 64'd0);
         check("idle_addr", mem_addr_o, 64'd0);
         push_exp(p, exp_err, exp_rdata, cyc + 2);
         @(posedge clk); #1;
         req_i[p] = 1'b0;
         addr_i[p] = ~addr;
         @(negedge clk);
         aligned = (addr[2:0] == 3'b000);
         check("access_write", {63'b0, mem_write_o}, {63'b0, we & aligned});
         check("access_read",  {63'b0, mem_read_o},  {63'b0, !we & aligned});
         check("access_addr",  mem_addr_o, addr);
         check("access_no_gnt", {62'b0, gnt_o}, 64'd0);
      end else begin
         req_i[p] = 1'b0;
      end
   endtask

   // Captures n grants while the caller holds both port-0 and port-1 read
   // requests; expects strict alternation starting with first_port and a
   // grant every second cycle.
   task automatic run_both(input int n, input logic first_port,
                           input logic [63:0] e0, input logic [63:0] e1);
      logic got;
      logic gp;
      logic [31:0] prev;
      prev = '0;
      for (int k = 0; k < n; k++) begin
         got = 1'b0;
         for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (gnt_o != 2'b00) begin got = 1'b1; break; end
         end
         check("rr_grant_seen", {63'b0, got}, 64'd1);
         if (!got) break;
         gp = gnt_o[1];
         check("rr_order", {62'b0, gnt_o},
               ((first_port ^ k[0]) == 1'b1) ? 64'd2 : 64'd1);
         if (k > 0) check("rr_spacing", {32'b0, cyc - prev}, 64'd2);
         prev = cyc;
         push_exp(gp, 1'b0, gp ? e1 : e0, cyc + 2);
      end
   endtask

   // ---------------- main sequence ----------------
   logic got_w;

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = INIT_BASE | 64'(i);
      req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0;

      // Both ports request reads from reset onwards: 0x40 (word 8), 0x48 (word 9)
      addr_i[0] = 64'h40; addr_i[1] = 64'h48; req_i = 2'b11;
      repeat (3) @(negedge clk);
      check("rst_gnt",    {62'b0, gnt_o}, 64'd0);
      check("rst_done",   {62'b0, done_o}, 64'd0);
      check("rst_err",    {62'b0, err_o}, 64'd0);
      check("rst_rdata",  rdata_o, 64'd0);
      check("rst_strobe", {62'b0, mem_read_o, mem_write_o}, 64'd0);
      check("rst_addr",   mem_addr_o, 64'd0);
      check("rst_wdata",  mem_wdata_o, 64'd0);
      check("rst_state",  {63'b0, dbg_state}, {63'b0, IDLE});
      @(posedge clk); #1;
      rst_n = 1'b1;
      run_both(8, 1'b0, INIT_BASE | 64'd8, INIT_BASE | 64'd9);
      @(posedge clk); #1;
      req_i = 2'b00;
      repeat (3) @(posedge clk);

      // Write then read back across ports; done cycle overlaps next grant
      single(1'b0, 1'b1, 64'h10, 64'hDEAD_BEEF_0000_0001, 1'b0, 64'd0);
      single(1'b1, 1'b0, 64'h10, 64'd0, 1'b0, 64'hDEAD_BEEF_0000_0001);
      // Misaligned read and write: no strobe, err set, rdata zero
      single(1'b0, 1'b0, 64'h13, 64'd0, 1'b1, 64'd0);
      single(1'b1, 1'b1, 64'h1C, 64'h0BAD_0BAD_0BAD_0BAD, 1'b1, 64'd0);
      // Word 3 must be untouched by the rejected write to 0x1C
      single(1'b0, 1'b0, 64'h18, 64'd0, 1'b0, INIT_BASE | 64'd3);
      repeat (4) @(posedge clk);

      // Reset during the ACCESS cycle of a port-0 write to 0x20 (word 4)
      @(posedge clk); #1;
      we_i[0] = 1'b1; addr_i[0] = 64'h20; wdata_i[0] = 64'h1234_5678_9ABC_DEF0; req_i[0] = 1'b1;
      got_w = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (gnt_o[0]) begin got_w = 1'b1; break; end
      end
      check("rstw_grant_seen", {63'b0, got_w}, 64'd1);
      @(posedge clk); #1;
      req_i[0] = 1'b0; we_i[0] = 1'b0;
      #1;
      check("rstw_write_before", {63'b0, mem_write_o}, 64'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check("rstw_write_dropped", {63'b0, mem_write_o}, 64'd0);
      check("rstw_addr_cleared",  mem_addr_o, 64'd0);
      check("rstw_state",         {63'b0, dbg_state}, {63'b0, IDLE});
      repeat (2) @(posedge clk);
      check("rstw_mem_intact", mem[4], INIT_BASE | 64'd4);

      // After reset, port 0 wins contention again even though it was last
      @(posedge clk); #1;
      rst_n = 1'b1;
      addr_i[0] = 64'h20; addr_i[1] = 64'h10; we_i = 2'b00; req_i = 2'b11;
      run_both(2, 1'b0, INIT_BASE | 64'd4, 64'hDEAD_BEEF_0000_0001);
      @(posedge clk); #1;
      req_i = 2'b00;
      repeat (5) @(posedge clk);

      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
